// File: rtl/e203_exu_excp_arb_if.sv
// ---------------------------------------------------------------------------
// e203_exu_excp_arb_if
//   Bundle of every signal of the EXU exception/interrupt arbiter except clock
//   and reset.
//   master : trap sources, interrupt controller, CSR file, IFU/EXU halt logic
//            and the flush consumer (the environment around the arbiter).
//   slave  : the arbiter itself.
//   Groups : exception channels (ch_*), interrupts (irq_*, status_mie,
//            oitf_empty), WFI (wfi_*, core_wfi), flush (flush_*, csr_mtvec),
//            CSR commit (cmt_*), and the excp_active status flag.
// ---------------------------------------------------------------------------
interface e203_exu_excp_arb_if #(
    parameter int EXCP_CH = 2,
    parameter int IRQ_NUM = 4,
    parameter int PC_W    = 32
);
    logic [EXCP_CH-1:0]           ch_valid;
    logic [EXCP_CH-1:0]           ch_ready;
    logic [EXCP_CH-1:0][4:0]      ch_cause;
    logic [EXCP_CH-1:0][PC_W-1:0] ch_pc;
    logic [EXCP_CH-1:0][PC_W-1:0] ch_badaddr;
    logic [IRQ_NUM-1:0]           irq_pend;
    logic [IRQ_NUM-1:0]           irq_en;
    logic                         status_mie;
    logic                         oitf_empty;
    logic [PC_W-1:0]              irq_epc;
    logic                         wfi_valid;
    logic                         wfi_ready;
    logic                         wfi_halt_req;
    logic                         wfi_halt_ifu_ack;
    logic                         wfi_halt_exu_ack;
    logic                         core_wfi;
    logic [PC_W-1:0]              csr_mtvec;
    logic                         flush_req;
    logic                         flush_ack;
    logic [PC_W-1:0]              flush_pc;
    logic                         cmt_ena;
    logic [PC_W-1:0]              cmt_epc;
    logic [PC_W-1:0]              cmt_badaddr;
    logic [31:0]                  cmt_cause;
    logic                         excp_active;

    modport master (
        output ch_valid, ch_cause, ch_pc, ch_badaddr,
        output irq_pend, irq_en, status_mie, oitf_empty, irq_epc,
        output wfi_valid, wfi_halt_ifu_ack, wfi_halt_exu_ack,
        output csr_mtvec, flush_ack,
        input  ch_ready, wfi_ready, wfi_halt_req, core_wfi,
        input  flush_req, flush_pc, cmt_ena, cmt_epc, cmt_badaddr, cmt_cause,
        input  excp_active
    );

    modport slave (
        input  ch_valid, ch_cause, ch_pc, ch_badaddr,
        input  irq_pend, irq_en, status_mie, oitf_empty, irq_epc,
        input  wfi_valid, wfi_halt_ifu_ack, wfi_halt_exu_ack,
        input  csr_mtvec, flush_ack,
        output ch_ready, wfi_ready, wfi_halt_req, core_wfi,
        output flush_req, flush_pc, cmt_ena, cmt_epc, cmt_badaddr, cmt_cause,
        output excp_active
    );
endinterface

// File: rtl/e203_exu_excp_arb.sv
// ---------------------------------------------------------------------------
// e203_exu_excp_arb
//   Commit-stage trap arbiter: fixed-priority pick among EXCP_CH exception
//   channels and IRQ_NUM level interrupts (index 0 highest in both groups,
//   exceptions above interrupts), registered flush request toward mtvec with
//   a req/ack handshake, one-cycle CSR commit strobe, and the WFI
//   halt/sleep/wake sequencer.
//   Ports : clk, rst_n (async, active-low), bus (e203_exu_excp_arb_if.slave).
//   Config: E203_EXCP_VECTORED_EN - when defined, interrupts taken with
//           mtvec[0]=1 jump to base + 4*cause; otherwise every trap goes to
//           the base address.
// ---------------------------------------------------------------------------
module e203_exu_excp_arb #(
    parameter int EXCP_CH  = 2,
    parameter int IRQ_NUM  = 4,
    parameter int PC_W     = 32,
    parameter int IRQ_BASE = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    e203_exu_excp_arb_if.slave   bus
);
    localparam int CW = (EXCP_CH > 1) ? $clog2(EXCP_CH) : 1;
    localparam int IW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_HALT, S_SLEEP} state_t;

    state_t          r_state;
    logic            r_flush_req, r_halt_req, r_core_wfi, r_active;
    logic            r_ifu_ack, r_exu_ack;
    logic [PC_W-1:0] r_flush_pc, r_epc, r_badaddr;
    logic [31:0]     r_cause;

    logic [CW-1:0]      w_ch_sel;
    logic               w_ch_any;
    logic [IRQ_NUM-1:0] w_irq_vec;
    logic [IW-1:0]      w_irq_sel;
    logic               w_irq_any, w_irq_take, w_wfi_ready;
    logic [30:0]        w_irq_code;
    logic [PC_W-1:0]    w_base, w_irq_pc;
    logic               w_unused;

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        w_ch_sel = '0;
        for (int i = EXCP_CH - 1; i >= 0; i--)
            if (bus.ch_valid[i]) w_ch_sel = CW'(i);
        w_irq_sel = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--)
            if (w_irq_vec[i]) w_irq_sel = IW'(i);
    end

    assign w_ch_any    = |bus.ch_valid;
    assign w_irq_vec   = bus.irq_pend & bus.irq_en;
    assign w_irq_any   = |w_irq_vec;
    assign w_irq_take  = !w_ch_any && bus.status_mie && bus.oitf_empty && w_irq_any;
    assign w_wfi_ready = (r_state == S_IDLE) && !w_ch_any && !w_irq_take && bus.oitf_empty;
    assign w_irq_code  = 31'(IRQ_BASE) + 31'(w_irq_sel);
    assign w_base      = {bus.csr_mtvec[PC_W-1:2], 2'b00};
    assign w_unused    = ^bus.csr_mtvec[1:0];

`ifdef E203_EXCP_VECTORED_EN
    assign w_irq_pc = bus.csr_mtvec[0] ? (w_base + (PC_W'(w_irq_code) << 2)) : w_base;
`else
    assign w_irq_pc = w_base;
`endif

    // Handshake readies are gated by rst_n so they read 0 while reset is held.
    assign bus.ch_ready     = (rst_n && r_state == S_IDLE && w_ch_any) ?
                              (EXCP_CH'(1) << w_ch_sel) : '0;
    assign bus.wfi_ready    = rst_n && w_wfi_ready;
    assign bus.flush_req    = r_flush_req;
    assign bus.flush_pc     = r_flush_pc;
    assign bus.cmt_ena      = r_flush_req && bus.flush_ack;
    assign bus.cmt_epc      = r_epc;
    assign bus.cmt_badaddr  = r_badaddr;
    assign bus.cmt_cause    = r_cause;
    assign bus.wfi_halt_req = r_halt_req;
    assign bus.core_wfi     = r_core_wfi;
    assign bus.excp_active  = r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_flush_req <= 1'b0;
            r_halt_req  <= 1'b0;
            r_core_wfi  <= 1'b0;
            r_active    <= 1'b0;
            r_ifu_ack   <= 1'b0;
            r_exu_ack   <= 1'b0;
            r_flush_pc  <= '0;
            r_epc       <= '0;
            r_badaddr   <= '0;
            r_cause     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ch_any) begin
                        r_epc       <= bus.ch_pc[w_ch_sel];
                        r_badaddr   <= bus.ch_badaddr[w_ch_sel];
                        r_cause     <= {27'b0, bus.ch_cause[w_ch_sel]};
                        r_flush_pc  <= w_base;
                        r_flush_req <= 1'b1;
                        r_active    <= 1'b1;
                        r_state     <= S_FLUSH;
                    end else if (w_irq_take) begin
                        r_epc       <= bus.irq_epc;
                        r_badaddr   <= '0;
                        r_cause     <= {1'b1, w_irq_code};
                        r_flush_pc  <= w_irq_pc;
                        r_flush_req <= 1'b1;
                        r_active    <= 1'b1;
                        r_state     <= S_FLUSH;
                    end else if (bus.wfi_valid && w_wfi_ready) begin
                        r_halt_req  <= 1'b1;
                        r_active    <= 1'b1;
                        r_state     <= S_HALT;
                    end
                end
                S_FLUSH: begin
                    if (bus.flush_ack) begin
                        r_flush_req <= 1'b0;
                        r_active    <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_HALT: begin
                    // Acks are sticky; an ack arriving this cycle counts too.
                    r_ifu_ack <= r_ifu_ack | bus.wfi_halt_ifu_ack;
                    r_exu_ack <= r_exu_ack | bus.wfi_halt_exu_ack;
                    if ((r_ifu_ack | bus.wfi_halt_ifu_ack) && (r_exu_ack | bus.wfi_halt_exu_ack)) begin
                        r_core_wfi <= 1'b1;
                        r_state    <= S_SLEEP;
                    end
                end
                S_SLEEP: begin
                    // Any enabled pending line wakes; mie only decides trap vs resume.
                    if (w_irq_any) begin
                        r_halt_req <= 1'b0;
                        r_core_wfi <= 1'b0;
                        r_ifu_ack  <= 1'b0;
                        r_exu_ack  <= 1'b0;
                        if (bus.status_mie) begin
                            r_epc       <= bus.irq_epc;
                            r_badaddr   <= '0;
                            r_cause     <= {1'b1, w_irq_code};
                            r_flush_pc  <= w_irq_pc;
                            r_flush_req <= 1'b1;
                            r_state     <= S_FLUSH;
                        end else begin
                            r_active <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_e203_exu_excp_arb.sv
module tb_e203_exu_excp_arb;
    localparam int EXCP_CH = 2, IRQ_NUM = 4, PC_W = 32, IRQ_BASE = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    e203_exu_excp_arb_if #(.EXCP_CH(EXCP_CH), .IRQ_NUM(IRQ_NUM), .PC_W(PC_W)) bus ();

    e203_exu_excp_arb #(.EXCP_CH(EXCP_CH), .IRQ_NUM(IRQ_NUM), .PC_W(PC_W), .IRQ_BASE(IRQ_BASE))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: trap-level view of the arbiter.
    typedef enum {M_IDLE, M_FLUSH, M_HALT, M_SLEEP} mode_t;
    mode_t       m_mode;
    bit          m_ifu, m_exu;
    logic [31:0] m_epc, m_bad, m_cause, m_fpc;

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_ifu = 0; m_exu = 0;
        m_epc = 0; m_bad = 0; m_cause = 0; m_fpc = 0;
    endtask

    task automatic take_irq(input int k);
        m_cause = 32'h8000_0000 | 32'(IRQ_BASE + k);
        m_epc   = bus.irq_epc;
        m_bad   = 0;
        m_fpc   = bus.csr_mtvec & ~32'h3;
`ifdef E203_EXCP_VECTORED_EN
        if (bus.csr_mtvec[0]) m_fpc = m_fpc + 32'(4 * (IRQ_BASE + k));
`endif
        m_mode = M_FLUSH;
    endtask

    task automatic check_outputs();
        int w, k;
        bit take, e_wrdy;
        logic [1:0] e_rdy;
        w = lowest(32'(bus.ch_valid));
        k = lowest(32'(bus.irq_pend & bus.irq_en));
        take   = (w < 0) && bus.status_mie && bus.oitf_empty && (k >= 0);
        e_rdy  = (rst_n && m_mode == M_IDLE && w >= 0) ? 2'(1 << w) : 2'b00;
        e_wrdy = rst_n && m_mode == M_IDLE && w < 0 && !take && bus.oitf_empty;
        chk("ch_ready", bus.ch_ready, e_rdy);
        chk("wfi_ready", bus.wfi_ready, e_wrdy);
        chk("flush_req", bus.flush_req, m_mode == M_FLUSH);
        chk("cmt_ena", bus.cmt_ena, m_mode == M_FLUSH && bus.flush_ack);
        chk("halt_req", bus.wfi_halt_req, m_mode == M_HALT || m_mode == M_SLEEP);
        chk("core_wfi", bus.core_wfi, m_mode == M_SLEEP);
        chk("excp_active", bus.excp_active, m_mode != M_IDLE);
        chk("flush_pc", bus.flush_pc, m_fpc);
        chk("cmt_epc", bus.cmt_epc, m_epc);
        chk("cmt_badaddr", bus.cmt_badaddr, m_bad);
        chk("cmt_cause", bus.cmt_cause, m_cause);
    endtask

    task automatic model_step();
        int w, k;
        bit take;
        if (!rst_n) begin model_reset(); return; end
        w = lowest(32'(bus.ch_valid));
        k = lowest(32'(bus.irq_pend & bus.irq_en));
        take = (w < 0) && bus.status_mie && bus.oitf_empty && (k >= 0);
        case (m_mode)
            M_IDLE: begin
                if (w >= 0) begin
                    m_epc   = bus.ch_pc[w];
                    m_bad   = bus.ch_badaddr[w];
                    m_cause = 32'(bus.ch_cause[w]);
                    m_fpc   = bus.csr_mtvec & ~32'h3;
                    m_mode  = M_FLUSH;
                end else if (take) take_irq(k);
                else if (bus.wfi_valid && bus.oitf_empty) m_mode = M_HALT;
            end
            M_FLUSH: if (bus.flush_ack) m_mode = M_IDLE;
            M_HALT: begin
                m_ifu = m_ifu | bus.wfi_halt_ifu_ack;
                m_exu = m_exu | bus.wfi_halt_exu_ack;
                if (m_ifu && m_exu) m_mode = M_SLEEP;
            end
            M_SLEEP: if (k >= 0) begin
                m_ifu = 0; m_exu = 0;
                if (bus.status_mie) take_irq(k); else m_mode = M_IDLE;
            end
        endcase
    endtask

    // Inputs are set just after a rising edge; outputs checked 1ns later.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        bus.ch_valid = '0; bus.ch_cause = '0; bus.ch_pc = '0; bus.ch_badaddr = '0;
        bus.irq_pend = '0; bus.irq_en = '0; bus.status_mie = 0; bus.oitf_empty = 1;
        bus.irq_epc = '0; bus.wfi_valid = 0; bus.wfi_halt_ifu_ack = 0;
        bus.wfi_halt_exu_ack = 0; bus.csr_mtvec = 32'h8000; bus.flush_ack = 0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        @(posedge clk); #1;
        step(); step();
        chk("rst_flush_req", bus.flush_req, 0);
        chk("rst_wfi_ready", bus.wfi_ready, 0);
        rst_n = 1;
        step();

        // Two simultaneous exceptions: channel 0 first, channel 1 held.
        bus.ch_valid = 2'b11;
        bus.ch_cause[0] = 5'd5;   bus.ch_cause[1] = 5'd7;
        bus.ch_pc[0] = 32'h100;   bus.ch_pc[1] = 32'h200;
        bus.ch_badaddr[0] = 32'h11; bus.ch_badaddr[1] = 32'h22;
        #1 chk("tp_ch_ready", bus.ch_ready, 2'b01);
        step();
        chk("tp_fpc", bus.flush_pc, 32'h8000);
        chk("tp_epc0", bus.cmt_epc, 32'h100);
        chk("tp_cause0", bus.cmt_cause, 32'd5);
        bus.ch_valid = 2'b10; bus.flush_ack = 1;
        #1 chk("tp_cmt_ena", bus.cmt_ena, 1);
        step();
        bus.flush_ack = 0;
        step();
        chk("tp_epc1", bus.cmt_epc, 32'h200);
        chk("tp_cause1", bus.cmt_cause, 32'd7);
        bus.ch_valid = 0; bus.flush_ack = 1;
        step();
        bus.flush_ack = 0;

        // Interrupt: lines 1 and 2 pending, line 1 wins.
        bus.irq_pend = 4'b0110; bus.irq_en = 4'b1111; bus.status_mie = 1;
        bus.irq_epc = 32'h44; bus.csr_mtvec = 32'h8001;
        step();
        chk("tp_irq_cause", bus.cmt_cause, 32'h8000_0011);
        chk("tp_irq_epc", bus.cmt_epc, 32'h44);
`ifdef E203_EXCP_VECTORED_EN
        chk("tp_irq_fpc", bus.flush_pc, 32'h8044);
`else
        chk("tp_irq_fpc", bus.flush_pc, 32'h8000);
`endif
        bus.flush_ack = 1; bus.irq_pend = 0;
        step();
        bus.flush_ack = 0; bus.csr_mtvec = 32'h8000;

        // WFI with skewed acks, wake with mie=0.
        bus.status_mie = 0; bus.wfi_valid = 1;
        step();
        bus.wfi_valid = 0;
        step();
        bus.wfi_halt_ifu_ack = 1; step();
        bus.wfi_halt_ifu_ack = 0; step(); step();
        chk("tp_wfi_before", bus.core_wfi, 0);
        bus.wfi_halt_exu_ack = 1; step();
        bus.wfi_halt_exu_ack = 0;
        chk("tp_wfi_after", bus.core_wfi, 1);
        step();
        bus.irq_pend = 4'b0100;
        step();
        chk("tp_wake0_halt", bus.wfi_halt_req, 0);
        chk("tp_wake0_flush", bus.flush_req, 0);
        bus.irq_pend = 0;
        step();

        // WFI wake with mie=1.
        bus.wfi_valid = 1; step();
        bus.wfi_valid = 0; bus.wfi_halt_ifu_ack = 1; bus.wfi_halt_exu_ack = 1; step();
        bus.wfi_halt_ifu_ack = 0; bus.wfi_halt_exu_ack = 0; step();
        bus.irq_pend = 4'b0001; bus.status_mie = 1;
        step();
        chk("tp_wake1_flush", bus.flush_req, 1);
        chk("tp_wake1_wfi", bus.core_wfi, 0);
        chk("tp_wake1_cause", bus.cmt_cause, 32'h8000_0010);
        bus.flush_ack = 1; bus.irq_pend = 0; step();
        bus.flush_ack = 0;

        // Backpressure then reset mid-FLUSH.
        bus.ch_valid = 2'b01; bus.ch_pc[0] = 32'h300;
        step();
        for (int i = 0; i < 10; i++) begin
            bus.ch_valid = 2'($urandom);
            step();
            chk("bp_fpc", bus.flush_pc, 32'h8000);
            chk("bp_req", bus.flush_req, 1);
        end
        rst_n = 0; bus.ch_valid = 0; model_reset();
        #1 chk("rst_mid_req", bus.flush_req, 0);
        chk("rst_mid_epc", bus.cmt_epc, 0);
        bus.flush_ack = 1;
        step(); step();
        bus.flush_ack = 0; rst_n = 1;
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.ch_valid   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            bus.ch_cause   = 10'($urandom);
            bus.ch_pc      = {$urandom, $urandom};
            bus.ch_badaddr = {$urandom, $urandom};
            bus.irq_pend   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
            bus.irq_en     = 4'($urandom);
            bus.status_mie = 1'($urandom);
            bus.oitf_empty = ($urandom_range(0, 3) != 0);
            bus.irq_epc    = $urandom;
            bus.csr_mtvec  = $urandom;
            bus.wfi_valid  = ($urandom_range(0, 3) == 0);
            bus.wfi_halt_ifu_ack = ($urandom_range(0, 2) == 0);
            bus.wfi_halt_exu_ack = ($urandom_range(0, 2) == 0);
            bus.flush_ack  = 1'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0; model_reset();
                step(); step();
                rst_n = 1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
